// File: rtl/xglib_pkg.sv
// Shared framebuffer types: coordinates, word addresses, pixel values and the fill FSM states.
package xglib_pkg;

    typedef logic [11:0] fb_coord_t;
    typedef logic [31:0] fb_addr_t;
    typedef logic [15:0] fb_pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } rect_fill_state_t;

endpackage

// File: rtl/rect_fill.sv
// Rectangle fill engine: one framebuffer write per pixel, row-major; bounds clipping when RECT_FILL_CLIP_EN is defined.
// First request 2 cycles after accept; each pixel is held until acked; new commands are accepted only in IDLE/DONE.
module rect_fill
    import xglib_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = 640,
    parameter int unsigned FB_HEIGHT = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [3:0]  WR_MASK   = 4'hF
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [11:0] cmd_x0_i,
    input  logic [11:0] cmd_y0_i,
    input  logic [11:0] cmd_x1_i,
    input  logic [11:0] cmd_y1_i,
    input  logic [15:0] cmd_color_i,
    output logic        busy_o,
    output logic        done_o,
    input  logic        vram_ack_i,
    output logic        vram_sel_o,
    output logic        vram_wr_o,
    output logic [3:0]  vram_mask_o,
    output logic [31:0] vram_addr_o,
    output logic [15:0] vram_data_out_o
);

`ifdef RECT_FILL_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    localparam fb_coord_t X_MAX  = fb_coord_t'(FB_WIDTH - 1);
    localparam fb_coord_t Y_MAX  = fb_coord_t'(FB_HEIGHT - 1);
    localparam fb_addr_t  STRIDE = fb_addr_t'(FB_WIDTH);

    rect_fill_state_t r_state, w_state_nxt;
    fb_coord_t r_x0, r_y0, r_x1, r_y1, r_cur_x, r_cur_y;
    fb_coord_t w_x0_nxt, w_y0_nxt, w_x1_nxt, w_y1_nxt, w_cur_x_nxt, w_cur_y_nxt;
    fb_pixel_t r_color, w_color_nxt;
    fb_addr_t  r_row_base, r_addr, w_row_base_nxt, w_addr_nxt;

    fb_coord_t w_x1_eff, w_y1_eff;
    fb_addr_t  w_row0;
    logic      w_empty;

    // Far corner clamped to the frame; a near corner off the frame empties the fill.
    assign w_x1_eff = (CLIP_EN && (r_x1 > X_MAX)) ? X_MAX : r_x1;
    assign w_y1_eff = (CLIP_EN && (r_y1 > Y_MAX)) ? Y_MAX : r_y1;
    assign w_empty  = (CLIP_EN && ((r_x0 > X_MAX) || (r_y0 > Y_MAX)))
                   || (r_x0 > w_x1_eff) || (r_y0 > w_y1_eff);
    assign w_row0   = fb_addr_t'(r_y0) * STRIDE;

    always_comb begin
        w_state_nxt    = r_state;
        w_x0_nxt       = r_x0;
        w_y0_nxt       = r_y0;
        w_x1_nxt       = r_x1;
        w_y1_nxt       = r_y1;
        w_cur_x_nxt    = r_cur_x;
        w_cur_y_nxt    = r_cur_y;
        w_color_nxt    = r_color;
        w_row_base_nxt = r_row_base;
        w_addr_nxt     = r_addr;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (cmd_valid_i) begin
                    w_x0_nxt    = cmd_x0_i;
                    w_y0_nxt    = cmd_y0_i;
                    w_x1_nxt    = cmd_x1_i;
                    w_y1_nxt    = cmd_y1_i;
                    w_color_nxt = cmd_color_i;
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (w_empty) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_x1_nxt       = w_x1_eff;
                    w_y1_nxt       = w_y1_eff;
                    w_cur_x_nxt    = r_x0;
                    w_cur_y_nxt    = r_y0;
                    w_row_base_nxt = w_row0;
                    w_addr_nxt     = BASE_ADDR + w_row0 + fb_addr_t'(r_x0);
                    w_state_nxt    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (vram_ack_i) begin
                    if (r_cur_x < r_x1) begin
                        w_cur_x_nxt = r_cur_x + 12'd1;
                        w_addr_nxt  = r_addr + 32'd1;
                    end else if (r_cur_y < r_y1) begin
                        w_cur_x_nxt    = r_x0;
                        w_cur_y_nxt    = r_cur_y + 12'd1;
                        w_row_base_nxt = r_row_base + STRIDE;
                        w_addr_nxt     = BASE_ADDR + r_row_base + STRIDE + fb_addr_t'(r_x0);
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state    <= ST_IDLE;
            r_x0       <= '0;
            r_y0       <= '0;
            r_x1       <= '0;
            r_y1       <= '0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_color    <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_x0       <= w_x0_nxt;
            r_y0       <= w_y0_nxt;
            r_x1       <= w_x1_nxt;
            r_y1       <= w_y1_nxt;
            r_cur_x    <= w_cur_x_nxt;
            r_cur_y    <= w_cur_y_nxt;
            r_color    <= w_color_nxt;
            r_row_base <= w_row_base_nxt;
            r_addr     <= w_addr_nxt;
        end
    end

    assign cmd_ready_o     = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign busy_o          = (r_state == ST_SETUP) || (r_state == ST_WRITE);
    assign done_o          = (r_state == ST_DONE);
    assign vram_sel_o      = (r_state == ST_WRITE);
    assign vram_wr_o       = (r_state == ST_WRITE);
    assign vram_mask_o     = WR_MASK;
    assign vram_addr_o     = r_addr;
    assign vram_data_out_o = r_color;

endmodule

// File: tb/tb_rect_fill.sv
// Directed bench for rect_fill: a pixel-list model predicts every framebuffer request and the done timing.
`timescale 1ns/1ps
module tb_rect_fill;

    localparam int          W    = 640;
    localparam int          H    = 480;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [11:0] cmd_x0_i = '0, cmd_y0_i = '0, cmd_x1_i = '0, cmd_y1_i = '0;
    logic [15:0] cmd_color_i = '0;
    logic        busy_o, done_o;
    logic        vram_ack_i = 1'b0;
    logic        vram_sel_o, vram_wr_o;
    logic [3:0]  vram_mask_o;
    logic [31:0] vram_addr_o;
    logic [15:0] vram_data_out_o;

    rect_fill #(.FB_WIDTH(W), .FB_HEIGHT(H), .BASE_ADDR(BASE), .WR_MASK(4'hF)) dut (
        .clk(clk), .reset_i(reset_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_x0_i(cmd_x0_i), .cmd_y0_i(cmd_y0_i), .cmd_x1_i(cmd_x1_i), .cmd_y1_i(cmd_y1_i),
        .cmd_color_i(cmd_color_i), .busy_o(busy_o), .done_o(done_o),
        .vram_ack_i(vram_ack_i), .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o),
        .vram_mask_o(vram_mask_o), .vram_addr_o(vram_addr_o), .vram_data_out_o(vram_data_out_o)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Model state: the pixels still owed and when the retire pulse is due.
    logic [31:0] exp_q[$];
    logic [15:0] exp_col;
    bit          m_idle = 1'b1;
    longint      done_at = -1, sel_from = 0;
    logic [31:0] wr_log[$];
    int          hold_cnt = 0, n_done = 0, wcnt = 0;
    longint      t_acc = 0, t_first = 0, t_done = 0;
    bit          first_seen = 1'b0;
    int          ack_delay = 0;
    bit          ack_idle = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic build(input int x0, input int y0, input int x1, input int y1);
`ifdef RECT_FILL_CLIP_EN
        if (x1 > W - 1) x1 = W - 1;
        if (y1 > H - 1) y1 = H - 1;
        if (x0 >= W || y0 >= H) return;
`endif
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                exp_q.push_back(32'(longint'(BASE) + longint'(y) * W + x));
    endtask

    task automatic monitor_step();
        bit exp_sel;
        if (cyc == done_at) begin
            m_idle = 1'b1;
            t_done = cyc;
        end
        chk("done_o", done_o, 64'(cyc == done_at));
        if (done_o) n_done++;
        chk("cmd_ready_o", cmd_ready_o, 64'(m_idle));
        chk("busy_o", busy_o, 64'(!m_idle));
        exp_sel = (exp_q.size() > 0) && (cyc >= sel_from);
        chk("vram_sel_o", vram_sel_o, 64'(exp_sel));
        chk("vram_wr_o", vram_wr_o, 64'(exp_sel));
        if (exp_sel) begin
            chk("vram_addr_o", vram_addr_o, exp_q[0]);
            chk("vram_data_out_o", vram_data_out_o, exp_col);
            chk("vram_mask_o", vram_mask_o, 4'hF);
            if (!first_seen) begin
                first_seen = 1'b1;
                t_first = cyc;
            end
        end
        // Framebuffer responder: ack after ack_delay waiting cycles; optional stray ack when idle.
        if (vram_sel_o) begin
            if (wcnt >= ack_delay) begin
                vram_ack_i = 1'b1;
                wcnt = 0;
            end else begin
                vram_ack_i = 1'b0;
                wcnt++;
            end
        end else begin
            vram_ack_i = ack_idle;
            wcnt = 0;
        end
        if (exp_sel && vram_sel_o && !vram_ack_i) hold_cnt++;
        if (exp_sel && vram_ack_i && !reset_i) begin
            wr_log.push_back(vram_addr_o);
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) done_at = cyc + 1;
        end
        if (reset_i) begin
            exp_q.delete();
            m_idle = 1'b1;
            done_at = -1;
        end else if (cmd_valid_i && m_idle) begin
            wr_log.delete();
            hold_cnt = 0;
            first_seen = 1'b0;
            exp_col = cmd_color_i;
            build(int'(cmd_x0_i), int'(cmd_y0_i), int'(cmd_x1_i), int'(cmd_y1_i));
            m_idle = 1'b0;
            t_acc = cyc;
            sel_from = cyc + 2;
            if (exp_q.size() == 0) done_at = cyc + 2;
        end
    endtask

    task automatic send(input int x0, input int y0, input int x1, input int y1, input logic [15:0] col);
        @(posedge clk);
        #1;
        cmd_x0_i = 12'(x0);
        cmd_y0_i = 12'(y0);
        cmd_x1_i = 12'(x1);
        cmd_y1_i = 12'(y1);
        cmd_color_i = col;
        cmd_valid_i = 1'b1;
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (m_idle) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 64'(ok), 64'd1);
        @(posedge clk);
    endtask

    logic [31:0] t1_addr [8] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd640, 32'd641, 32'd642, 32'd643};

    initial begin
        int nd;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", cmd_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_sel", vram_sel_o, 0);
        chk("rst_wr", vram_wr_o, 0);
        chk("rst_addr", vram_addr_o, 0);
        chk("rst_data", vram_data_out_o, 0);
        @(posedge clk);
        #1 reset_i = 1'b0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // 4x2 block, ack every cycle, stray acks while idle
        ack_delay = 0;
        ack_idle = 1'b1;
        send(0, 0, 3, 1, 16'h0F00);
        wait_idle("t1_retire", 100);
        chk("t1_count", wr_log.size(), 8);
        for (int i = 0; i < 8 && i < wr_log.size(); i++) chk("t1_addr", wr_log[i], t1_addr[i]);
        chk("t1_first_lat", t_first - t_acc, 2);
        chk("t1_done_cycle_from_first_sel", t_done - t_first + 1, 9);

        // Single pixel, ack after 3 waiting cycles
        ack_idle = 1'b0;
        ack_delay = 3;
        send(5, 5, 5, 5, 16'h0ABC);
        wait_idle("t2_retire", 100);
        chk("t2_count", wr_log.size(), 1);
        if (wr_log.size() > 0) chk("t2_addr", wr_log[0], 32'd3205);
        chk("t2_hold", hold_cnt, 3);
        chk("t2_data", vram_data_out_o, 16'h0ABC);

        // Inverted corners: no writes, retire 2 cycles after accept
        ack_delay = 0;
        send(10, 0, 2, 0, 16'h0123);
        wait_idle("t3_retire", 50);
        chk("t3_count", wr_log.size(), 0);
        chk("t3_done_lat", t_done - t_acc, 2);

        // Reset in the middle of a fill
        nd = n_done;
        send(0, 0, 9, 0, 16'h0555);
        for (int i = 0; i < 50 && wr_log.size() < 3; i++) @(posedge clk);
        chk("t4_reached_3_acks", 64'(wr_log.size() >= 3), 1);
        #1 reset_i = 1'b1;
        @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("t4_sel_after_reset", vram_sel_o, 0);
        chk("t4_ready_after_reset", cmd_ready_o, 1);
        repeat (5) @(posedge clk);
        chk("t4_no_done", n_done, nd);

        // Command pulsed while busy is dropped
        ack_delay = 1;
        send(20, 2, 27, 3, 16'h0777);
        repeat (4) @(posedge clk);
        #1;
        cmd_x0_i = 12'd0; cmd_y0_i = 12'd0; cmd_x1_i = 12'd0; cmd_y1_i = 12'd0;
        cmd_valid_i = 1'b1;
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
        wait_idle("t5_retire", 200);
        chk("t5_count", wr_log.size(), 16);
        if (wr_log.size() == 16) chk("t5_last", wr_log[15], 32'd1947);

        ack_delay = 0;
`ifdef RECT_FILL_CLIP_EN
        send(636, 478, 700, 900, 16'h0FFF);
        wait_idle("t6_retire", 200);
        chk("t6_count", wr_log.size(), 8);
        if (wr_log.size() == 8) chk("t6_last", wr_log[7], 32'd307199);
        send(700, 0, 710, 0, 16'h0FFF);
        wait_idle("t7_retire", 50);
        chk("t7_count", wr_log.size(), 0);
`else
        send(638, 1, 641, 1, 16'h0FFF);
        wait_idle("t6_retire", 200);
        chk("t6_count", wr_log.size(), 4);
        if (wr_log.size() == 4) chk("t6_last", wr_log[3], 32'd1281);
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
